// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and the byte width used on
// every UART data path.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of 'valid' at or after 'ptr',
// wrapping N-1 -> 0. Shared by the bus arbiters.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (int'(ptr) + i) % N;
      if (!any && valid[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = PW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Message-granular round-robin arbiter in front of the UART transmit write FIFO.
// Define UART_ARB_PRIO_EN to make requester 0 a high-priority requester.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_BEATS = 64,
  parameter int TIMEOUT   = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid_i,
  input  logic [UART_BYTE_W*NREQ-1:0] req_data_i,
  input  logic [NREQ-1:0]             req_last_i,
  output logic [NREQ-1:0]             req_ready_o,
  output logic                        wf_we_o,
  output logic [UART_BYTE_W-1:0]      wf_wdata_o,
  input  logic                        wf_full_i,
  output logic [NREQ-1:0]             gnt_o,
  output logic                        abort_o
);

  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  arb_state_t       state, state_nxt;
  logic [PW-1:0]    rr_ptr, rr_ptr_nxt, ptr_adv;
  logic [PW-1:0]    gnt_idx;
  logic [NREQ-1:0]  gnt_oh;
  logic [BW-1:0]    beat_cnt;
  logic [IW-1:0]    idle_cnt;

  logic [NREQ-1:0]  pick_valid, pick_oh, sel_oh;
  logic [PW-1:0]    pick_idx, sel_idx;
  logic             pick_any, sel_any;

  logic             cur_valid, cur_last, xfer, beat_hit, idle_hit, release_now;
  logic [UART_BYTE_W-1:0] cur_data;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .valid  (pick_valid),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Requester 0 bypasses the rotation when priority mode is built in.
  always_comb begin
    pick_valid = req_valid_i;
    sel_oh     = pick_oh;
    sel_idx    = pick_idx;
    sel_any    = pick_any;
`ifdef UART_ARB_PRIO_EN
    pick_valid[0] = 1'b0;
    if (req_valid_i[0]) begin
      sel_oh    = '0;
      sel_oh[0] = 1'b1;
      sel_idx   = '0;
      sel_any   = 1'b1;
    end
`endif
  end

  always_comb begin
    cur_valid   = req_valid_i[gnt_idx];
    cur_last    = req_last_i[gnt_idx];
    cur_data    = req_data_i[gnt_idx*UART_BYTE_W +: UART_BYTE_W];
    xfer        = (state == ARB_LOCK) && cur_valid && !wf_full_i;
    beat_hit    = xfer && !cur_last && (beat_cnt == BW'(MAX_BEATS - 1));
    idle_hit    = (state == ARB_LOCK) && !cur_valid && (idle_cnt == IW'(TIMEOUT - 1));
    release_now = (xfer && cur_last) || beat_hit || idle_hit;
  end

  // Pointer after releasing owner gnt_idx; a priority grant leaves it untouched.
  always_comb begin
    ptr_adv = rr_ptr;
`ifdef UART_ARB_PRIO_EN
    if (gnt_idx == '0)
      ptr_adv = rr_ptr;
    else if (int'(gnt_idx) == NREQ - 1)
      ptr_adv = PW'(1);
    else
      ptr_adv = gnt_idx + PW'(1);
`else
    if (int'(gnt_idx) == NREQ - 1)
      ptr_adv = '0;
    else
      ptr_adv = gnt_idx + PW'(1);
`endif
  end

  always_comb begin
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    wf_we_o     = 1'b0;
    wf_wdata_o  = '0;
    req_ready_o = '0;
    gnt_o       = '0;
    abort_o     = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (sel_any) state_nxt = ARB_LOCK;
      end
      ARB_LOCK: begin
        wf_we_o     = cur_valid && !wf_full_i;
        wf_wdata_o  = cur_data;
        req_ready_o = gnt_oh & {NREQ{!wf_full_i}};
        gnt_o       = gnt_oh;
        abort_o     = beat_hit || idle_hit;
        if (release_now) begin
          state_nxt  = ARB_IDLE;
          rr_ptr_nxt = ptr_adv;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      gnt_idx  <= '0;
      gnt_oh   <= '0;
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      if (state == ARB_IDLE && sel_any) begin
        gnt_idx  <= sel_idx;
        gnt_oh   <= sel_oh;
        beat_cnt <= '0;
        idle_cnt <= '0;
      end else if (state == ARB_LOCK) begin
        if (xfer) beat_cnt <= beat_cnt + BW'(1);
        // A full-FIFO stall with valid held is not idleness.
        if (cur_valid) idle_cnt <= '0;
        else           idle_cnt <= idle_cnt + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb (NREQ=4, MAX_BEATS=4, TIMEOUT=8); requesters are
// byte queues, FIFO writes are logged with their cycle offset and compared.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data  = '0;
  logic [3:0]  req_last  = '0;
  logic [3:0]  req_ready;
  logic        wf_we;
  logic [7:0]  wf_wdata;
  logic        wf_full = 1'b0;
  logic [3:0]  gnt;
  logic        abort;

  always #5 clk = ~clk;

  uart_tx_arb #(.NREQ(4), .MAX_BEATS(4), .TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .wf_we_o     (wf_we),
    .wf_wdata_o  (wf_wdata),
    .wf_full_i   (wf_full),
    .gnt_o       (gnt),
    .abort_o     (abort)
  );

  typedef struct { logic [7:0] d; logic l; } beat_t;
  typedef struct { int rel; logic [3:0] owner; logic [7:0] data; } wr_t;

  beat_t q [4][$];
  wr_t   wr_log[$];
  int    abort_log[$];
  int    err_count = 0;
  int    check_count = 0;
  int    cyc = 0;
  int    base = 0;
  logic [3:0] s_gnt, s_ready;
  logic       s_we, s_abort;
  logic [7:0] s_data;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    for (int k = 0; k < 4; k++) begin
      if (q[k].size() > 0) begin
        req_valid[k]       = 1'b1;
        req_data[k*8 +: 8] = q[k][0].d;
        req_last[k]        = q[k][0].l;
      end else begin
        req_valid[k]       = 1'b0;
        req_data[k*8 +: 8] = 8'h00;
        req_last[k]        = 1'b0;
      end
    end
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    q[k].push_back(b);
  endtask

  task automatic step();
    logic [3:0] pop;
    wr_t w;
    @(negedge clk);
    s_gnt   = gnt;
    s_we    = wf_we;
    s_data  = wf_wdata;
    s_ready = req_ready;
    s_abort = abort;
    pop     = req_valid & req_ready;
    if (wf_we) begin
      w.rel   = cyc - base;
      w.owner = gnt;
      w.data  = wf_wdata;
      wr_log.push_back(w);
    end
    if (abort) abort_log.push_back(cyc - base);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++)
      if (pop[k] && q[k].size() > 0) q[k].delete(0);
    cyc++;
    applyStimulus();
  endtask

  task automatic startTest();
    wr_log.delete();
    abort_log.delete();
    base = cyc;
  endtask

  task automatic doReset();
    rst     = 1'b1;
    wf_full = 1'b0;
    for (int k = 0; k < 4; k++) q[k].delete();
    applyStimulus();
    step();
    step();
    rst = 1'b0;
    startTest();
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done && n < max_cyc) begin
      step();
      n++;
      done = (s_gnt == 4'b0) && q[0].size() == 0 && q[1].size() == 0 &&
             q[2].size() == 0 && q[3].size() == 0;
    end
    checkOutput({tag, "_drained"}, 32'(done), 32'd1);
  endtask

  task automatic checkWrite(input string tag, input int i, input int rel,
                            input logic [3:0] owner, input logic [7:0] data);
    logic [31:0] obs;
    if (i < wr_log.size()) begin
      obs = {wr_log[i].rel[15:0], 4'h0, wr_log[i].owner, wr_log[i].data};
    end else begin
      obs = 32'hFFFF_FFFF;
    end
    checkOutput($sformatf("%s_wr%0d", tag, i), obs, {rel[15:0], 4'h0, owner, data});
  endtask

  task automatic checkCounts(input string tag, input int n_wr, input int n_abort);
    checkOutput({tag, "_nwrites"}, 32'(wr_log.size()), 32'(n_wr));
    checkOutput({tag, "_naborts"}, 32'(abort_log.size()), 32'(n_abort));
  endtask

  initial begin
    // Reset state with nothing requesting.
    doReset();
    step();
    checkOutput("rst_gnt",   32'(s_gnt),   32'h0);
    checkOutput("rst_we",    32'(s_we),    32'h0);
    checkOutput("rst_ready", 32'(s_ready), 32'h0);
    checkOutput("rst_abort", 32'(s_abort), 32'h0);
    checkOutput("rst_wdata", 32'(s_data),  32'h0);

    // Single requester 2, three-byte message.
    push(2, 8'h41, 1'b0);
    push(2, 8'h42, 1'b0);
    push(2, 8'h43, 1'b1);
    applyStimulus();
    startTest();
    step();
    checkOutput("t1_idle_gnt", 32'(s_gnt), 32'h0);
    checkOutput("t1_idle_we",  32'(s_we),  32'h0);
    step();
    checkOutput("t1_gnt",   32'(s_gnt),   32'h4);
    checkOutput("t1_ready", 32'(s_ready), 32'h4);
    drain("t1", 20);
    checkCounts("t1", 3, 0);
    checkWrite("t1", 0, 1, 4'b0100, 8'h41);
    checkWrite("t1", 1, 2, 4'b0100, 8'h42);
    checkWrite("t1", 2, 3, 4'b0100, 8'h43);

    // rr_ptr is now 3: R3 beats R0.
    push(0, 8'h50, 1'b1);
    push(3, 8'h53, 1'b1);
    applyStimulus();
    startTest();
    drain("ptr3", 20);
    checkCounts("ptr3", 2, 0);
    checkWrite("ptr3", 0, 1, 4'b1000, 8'h53);
    checkWrite("ptr3", 1, 3, 4'b0001, 8'h50);

    // All four requesters with two-byte messages from rr_ptr=0.
    doReset();
    for (int k = 0; k < 4; k++) begin
      push(k, 8'((k << 4) | 0), 1'b0);
      push(k, 8'((k << 4) | 1), 1'b1);
    end
    applyStimulus();
    startTest();
    drain("t2", 40);
    checkCounts("t2", 8, 0);
    for (int k = 0; k < 4; k++)
      for (int b = 0; b < 2; b++)
        checkWrite("t2", 2*k + b, 3*k + 1 + b, 4'(1 << k), 8'((k << 4) | b));

    // FIFO full for 10 cycles mid-message, longer than TIMEOUT; 4 bytes = MAX_BEATS with last.
    doReset();
    push(1, 8'hA0, 1'b0);
    push(1, 8'hA1, 1'b0);
    push(1, 8'hA2, 1'b0);
    push(1, 8'hA3, 1'b1);
    applyStimulus();
    startTest();
    step();
    step();
    wf_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput($sformatf("t3_stall%0d", i), {22'h0, s_gnt, s_ready, s_we, s_abort},
                  {22'h0, 4'b0010, 4'b0000, 1'b0, 1'b0});
    end
    wf_full = 1'b0;
    drain("t3", 20);
    checkCounts("t3", 4, 0);
    checkWrite("t3", 0, 1,  4'b0010, 8'hA0);
    checkWrite("t3", 1, 12, 4'b0010, 8'hA1);
    checkWrite("t3", 2, 13, 4'b0010, 8'hA2);
    checkWrite("t3", 3, 14, 4'b0010, 8'hA3);

    // MAX_BEATS=4: six bytes without last; then the tail times out.
    doReset();
    for (int i = 0; i < 6; i++) push(1, 8'(8'hB0 + i), 1'b0);
    applyStimulus();
    startTest();
    drain("t4", 60);
    checkCounts("t4", 6, 2);
    for (int i = 0; i < 4; i++) checkWrite("t4", i, 1 + i, 4'b0010, 8'(8'hB0 + i));
    checkWrite("t4", 4, 6, 4'b0010, 8'hB4);
    checkWrite("t4", 5, 7, 4'b0010, 8'hB5);
    checkOutput("t4_abort0", (abort_log.size() > 0) ? 32'(abort_log[0]) : 32'hFFFF, 32'd4);
    checkOutput("t4_abort1", (abort_log.size() > 1) ? 32'(abort_log[1]) : 32'hFFFF, 32'd15);

    // TIMEOUT=8: R3 stalls after one byte, R0 waits then gets the bus.
    doReset();
    push(3, 8'hC0, 1'b0);
    applyStimulus();
    startTest();
    step();
    step();
    step();
    push(0, 8'hD0, 1'b1);
    applyStimulus();
    drain("t5", 40);
    checkCounts("t5", 2, 1);
    checkWrite("t5", 0, 1,  4'b1000, 8'hC0);
    checkWrite("t5", 1, 11, 4'b0001, 8'hD0);
    checkOutput("t5_abort", (abort_log.size() > 0) ? 32'(abort_log[0]) : 32'hFFFF, 32'd9);

    // Set rr_ptr=2 through an R1 message, then R0 and R2 compete.
    doReset();
    push(1, 8'hE0, 1'b1);
    applyStimulus();
    startTest();
    drain("t6a", 20);
    checkWrite("t6a", 0, 1, 4'b0010, 8'hE0);
    push(0, 8'hF0, 1'b1);
    push(2, 8'hF2, 1'b1);
    applyStimulus();
    startTest();
    drain("t6", 20);
    checkCounts("t6", 2, 0);
`ifdef UART_ARB_PRIO_EN
    checkWrite("t6", 0, 1, 4'b0001, 8'hF0);
    checkWrite("t6", 1, 3, 4'b0100, 8'hF2);
`else
    checkWrite("t6", 0, 1, 4'b0100, 8'hF2);
    checkWrite("t6", 1, 3, 4'b0001, 8'hF0);
`endif

    // Reset asserted mid-message.
    doReset();
    push(2, 8'h70, 1'b0);
    push(2, 8'h71, 1'b0);
    push(2, 8'h72, 1'b0);
    applyStimulus();
    startTest();
    step();
    step();
    checkOutput("rstmid_pre_gnt", 32'(s_gnt), 32'h4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    checkOutput("rstmid_gnt",   32'(s_gnt),   32'h0);
    checkOutput("rstmid_we",    32'(s_we),    32'h0);
    checkOutput("rstmid_abort", 32'(s_abort), 32'h0);
    doReset();

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
